multiplier_iterative_unit: RTL and testbench

Unsigned 32×32→64 sequential shift-and-add multiplier. It resolves one multiplier bit per clock, trading latency for area. It serves as a functional unit alongside the ALU: it takes a one-cycle start pulse with operands and returns the full-width product with a one-cycle completion pulse. Module name: `multiplier_iterative_unit`.

---
 rtl/multiplier_iterative_pkg.sv | 13 +
 rtl/multiplier_iterative_unit.sv | 91 +++++++++
 tb/tb_multiplier_iterative_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_iterative_pkg.sv
// Shared types and sizing for the iterative shift-and-add multiplier.
package multiplier_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

endpackage

// File: rtl/multiplier_iterative_unit.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH sequential shift-and-add multiplier, one multiplier bit per clock.
// Optional macro MULT_ITER_EARLY_TERM_EN finishes as soon as no set multiplier bits remain.
module multiplier_iterative_unit
  import multiplier_iterative_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               valid_out,
  output logic [2*WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Handshake: there is no ready. valid_in is accepted only on an edge where the unit
  // is IDLE or DONE; a request while BUSY is dropped. valid_out is a one-cycle pulse
  // with r valid from that cycle until the next completion.
  mult_state_t state;
  mult_state_t state_next;

  logic [2*WIDTH-1:0] m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_sum;
  logic [WIDTH-1:0]   q_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               start;
  logic               finish;

  always_comb begin
    p_sum = q_q[0] ? (p_q + m_q) : p_q;
    start = valid_in && (state != BUSY);
`ifdef MULT_ITER_EARLY_TERM_EN
    // Nothing left above the current bit means this iteration's add is the last one.
    finish = (state == BUSY) && ((cnt_q == LAST_ITER) || ((q_q >> 1) == '0));
`else
    finish = (state == BUSY) && (cnt_q == LAST_ITER);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (finish) state_next = DONE;
      DONE:    state_next = start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      r         <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (start) begin
        m_q   <= {{WIDTH{1'b0}}, a};
        q_q   <= b;
        p_q   <= '0;
        cnt_q <= '0;
      end else if (state == BUSY) begin
        p_q   <= p_sum;
        m_q   <= m_q << 1;
        q_q   <= q_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (finish) begin
          r         <= p_sum;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_iterative_unit.sv
// Self-checking bench for multiplier_iterative_unit; latency expectations follow MULT_ITER_EARLY_TERM_EN.
module tb_multiplier_iterative_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid_in = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           valid_out;
  logic [2*W-1:0] r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pulse_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  multiplier_iterative_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .r         (r)
  );

  // ---------------- clock / counters ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_out) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference ----------------
  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = {{W{1'b0}}, av};
    bx = {{W{1'b0}}, bv};
    return ax * bx;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MULT_ITER_EARLY_TERM_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (bv[i]) return i + 1;
    end
    return 1;
`else
    return W;
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
    @(negedge clk);
    a = av;
    b = bv;
    valid_in = 1'b1;
    if (push) exp_q.push_back(model_mul(av, bv));
    @(negedge clk);
    valid_in = 1'b0;
    if (push) start_cyc = cyc;
  endtask

  // Waits for the completion pulse and pops the scoreboard against r.
  task automatic wait_done(output int lat);
    bit found;
    logic [2*W-1:0] e;
    found = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL done_timeout: valid_out=0 after 40 cycles, required a pulse");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      lat = cyc - start_cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: r=%h with empty expected queue", r);
      end else begin
        e = exp_q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL product: r=%h, required %h", r, e);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lat;
    int pc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || r !== '0) begin
      errors++;
      $display("FAIL reset_hold: valid_out=%b r=%h, required 0 and 0", valid_out, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || r !== '0) begin
      errors++;
      $display("FAIL reset_release: valid_out=%b r=%h, required 0 and 0", valid_out, r);
    end
    issue(32'h0000_DEAD, 32'h8000_BEEF, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    pc = pulse_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (pulse_cnt != pc) begin
      errors++;
      $display("FAIL reset_midbusy_pulse: %0d pulses after reset, required 0", pulse_cnt - pc);
    end
    checks++;
    if (r !== '0) begin
      errors++;
      $display("FAIL reset_midbusy_r: r=%h, required 0", r);
    end
    issue(32'd6, 32'd7, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != exp_lat(32'd7)) begin
      errors++;
      $display("FAIL reset_restart_latency: %0d cycles, required %0d", lat, exp_lat(32'd7));
    end
  endtask

  task automatic test_sweep();
    int lat;
    for (int i = 0; i < 100; i++) begin
      issue(W'(i), W'(i), 1'b1);
      wait_done(lat);
      checks++;
      if (lat != exp_lat(W'(i))) begin
        errors++;
        $display("FAIL sweep_latency[%0d]: %0d cycles, required %0d", i, lat, exp_lat(W'(i)));
      end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL sweep_pulse_width[%0d]: valid_out=%b one cycle later, required 0", i, valid_out);
      end
    end
    checks++;
    if (r !== 64'd9801) begin
      errors++;
      $display("FAIL sweep_last: r=%0d, required 9801", r);
    end
  endtask

  task automatic test_stride();
    int lat;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = 32'h0000_0001;
    bv = 32'h0000_0002;
    for (int i = 0; i < 100; i++) begin
      issue(av, bv, 1'b1);
      wait_done(lat);
      checks++;
      if (lat != exp_lat(bv)) begin
        errors++;
        $display("FAIL stride_latency[%0d]: %0d cycles, required %0d", i, lat, exp_lat(bv));
      end
      av = av + 32'h2345_6789;
      bv = bv + 32'h3456_7891;
    end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    checks++;
    if (r !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL stride_max: r=%h, required fffffffe00000001", r);
    end
  endtask

  task automatic test_latency();
    int lat;
    logic [W-1:0] bs[7];
    bs[0] = 32'h0000_0001;
    bs[1] = 32'h8000_0000;
    bs[2] = 32'h0000_0000;
    bs[3] = 32'h0000_0010;
    bs[4] = $urandom;
    bs[5] = $urandom_range(1, 255);
    bs[6] = $urandom_range(0, 65535);
    foreach (bs[i]) begin
      issue($urandom, bs[i], 1'b1);
      wait_done(lat);
      checks++;
      if (lat != exp_lat(bs[i])) begin
        errors++;
        $display("FAIL latency[b=%h]: %0d cycles, required %0d", bs[i], lat, exp_lat(bs[i]));
      end
    end
  endtask

  task automatic test_busy_hold();
    int lat;
    int pc;
    logic [2*W-1:0] prev;
    prev = r;
    issue(32'h0000_1234, 32'h8000_0003, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (r !== prev || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold[%0d]: r=%h valid_out=%b, required r=%h valid_out=0", k, r, valid_out, prev);
      end
      if (k == 5) begin
        a = 32'd99;
        b = 32'd99;
        valid_in = 1'b1;
      end
      if (k == 6) valid_in = 1'b0;
      @(negedge clk);
    end
    wait_done(lat);
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL busy_latency: %0d cycles, required %0d", lat, W);
    end
    @(negedge clk);
    pc = pulse_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (pulse_cnt != pc) begin
      errors++;
      $display("FAIL busy_no_restart: %0d extra pulses, required 0", pulse_cnt - pc);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(32'd7, 32'd9, 1'b1);
    wait_done(lat);
    a = 32'd3;
    b = 32'd5;
    valid_in = 1'b1;
    exp_q.push_back(model_mul(32'd3, 32'd5));
    @(negedge clk);
    valid_in = 1'b0;
    start_cyc = cyc;
    checks++;
    if (valid_out !== 1'b0 || r !== 64'd63) begin
      errors++;
      $display("FAIL b2b_hold: valid_out=%b r=%0d, required 0 and 63", valid_out, r);
    end
    wait_done(lat);
    checks++;
    if (lat != exp_lat(32'd5)) begin
      errors++;
      $display("FAIL b2b_latency: %0d cycles, required %0d", lat, exp_lat(32'd5));
    end
    checks++;
    if (r !== 64'd15) begin
      errors++;
      $display("FAIL b2b_second: r=%0d, required 15", r);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_sweep();
    test_stride();
    test_latency();
    test_busy_hold();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
